regfile_wr_arbiter: RTL
=======================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have ports a_req, a_addr, a_data: inputs of 1, 5 and 32 bits; requester A write request, target register and write data.
REQ-004 The block SHALL have ports b_req, b_addr, b_data: inputs of 1, 5 and 32 bits; requester B write request, target register and write data.
REQ-005 The block SHALL have ports a_ack and b_ack: outputs of 1 bit each; one-cycle grant pulse per accepted request.
REQ-006 The block SHALL have port clr_req: input, 1 bit; a one-cycle pulse that starts a register-file clear sweep.
REQ-007 The block SHALL have ports busy and clr_done: outputs of 1 bit each; busy is high while a sweep runs, clr_done pulses for one cycle when a sweep ends.
REQ-008 The block SHALL have ports D_En, D_Addr, D: outputs of 1, 5 and 32 bits; the register-file write port.

Function
REQ-009 All outputs SHALL be registered.
REQ-010 The FSM SHALL have two states, IDLE and CLEAR.
REQ-011 In IDLE, the block SHALL grant at most one eligible requester per rising edge.
REQ-012 A requester SHALL be eligible when its req is 1 and its ack is currently 0, so a held req is never granted twice.
REQ-013 A grant SHALL, at the same edge, set the winner's ack to 1 for exactly one cycle and set D_Addr and D to the winner's addr and data.
REQ-014 A grant SHALL also set D_En to 1, except when the winner's addr is 0, in which case D_En SHALL be 0: register 0 is never written, but the request is still acked.
REQ-015 When both requesters are eligible, the winner SHALL be chosen per REQ-025/REQ-026.
REQ-016 When no requester is eligible, D_En SHALL be 0, both acks SHALL be 0, and D_Addr and D SHALL hold their previous values.
REQ-017 A clr_req sampled in IDLE SHALL take priority over pending requests: the block enters CLEAR at that edge, grants nothing, and sets busy to 1.
REQ-018 In CLEAR, the block SHALL drive D_En=1 and D=0 with D_Addr = 1, 2, ..., 31 on consecutive cycles (31 writes).
REQ-019 After the write to address 31, the block SHALL return to IDLE, set busy to 0, and pulse clr_done for one cycle.
REQ-020 In CLEAR, both acks SHALL stay 0; requests SHALL remain pending, and the block SHALL NOT drop them.
REQ-021 A clr_req sampled during CLEAR SHALL be ignored and SHALL NOT restart the sweep.
REQ-022 Arbitration SHALL resume on the first edge after clr_done.

Reset
REQ-023 On reset low, regardless of clk, the block SHALL immediately force state=IDLE; D_En, a_ack, b_ack, busy, clr_done=0; D_Addr=0; D=0; and the priority pointer to A.
REQ-024 Reset asserted mid-sweep SHALL abort the sweep with no clr_done; after release, the block SHALL be idle and accept requests on the next edge.

Configuration
REQ-025 With macro WR_ARB_ROUND_ROBIN_EN defined, simultaneous eligible requests SHALL alternate: the pointer moves to the non-winner after every grant, and the first contention after reset goes to A.
REQ-026 With WR_ARB_ROUND_ROBIN_EN undefined, requester A SHALL always win contention (fixed priority), and the pointer logic SHALL NOT be built.

Verification
REQ-027 Reset, then a_req=1, a_addr=5, a_data=32'hDEADBEEF held high -> exactly one a_ack; D_En=1, D_Addr=5, D=32'hDEADBEEF in the same cycle; no second grant.
REQ-028 a_req and b_req high every cycle, addrs 3 and 4, round-robin on -> acks alternate A,B,A,B; round-robin off -> A wins every eligible cycle, and B is granted only in cycles where A is ineligible.
REQ-029 b_req with b_addr=0, b_data=32'h1234 -> b_ack=1 with D_En=0.
REQ-030 clr_req pulse with a_req held -> busy high for 31 cycles; D_Addr steps 1..31 with D=0 and D_En=1; one clr_done pulse; a_ack on the first edge after clr_done.
REQ-031 reset driven low at sweep write 10 -> all outputs 0 immediately; no clr_done; after release, an a_req to addr 7 is granted normally.
REQ-032 Full-file check -> write 32'h00010001*i to registers 1..30 via alternating requesters, clear sweep, then a scoreboard readback of all 32 registers shows 0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Two-requester write arbiter for a 32-entry register file, with a clear sweep of registers 1..31.
// Define WR_ARB_ROUND_ROBIN_EN for alternating priority; otherwise requester A always wins contention.
module regfile_wr_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_req,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic        clr_req,
  output logic        a_ack,
  output logic        b_ack,
  output logic        busy,
  output logic        clr_done,
  output logic        D_En,
  output logic [4:0]  D_Addr,
  output logic [31:0] D
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state_q, state_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        busy_q, busy_d;
  logic        clr_done_q, clr_done_d;
  logic        d_en_q, d_en_d;
  logic [4:0]  d_addr_q, d_addr_d;
  logic [31:0] d_q, d_d;
  logic        a_elig, b_elig;
  logic        grant_a, grant_b;

  // A requester whose ack is currently high sits out one cycle, so a held req is not re-granted back to back.
  assign a_elig = a_req & ~a_ack_q;
  assign b_elig = b_req & ~b_ack_q;

`ifdef WR_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;  // 0: A wins the next contention, 1: B wins

  assign grant_a = a_elig & (~b_elig | ~ptr_q);
  assign grant_b = b_elig & (~a_elig |  ptr_q);
`else
  assign grant_a = a_elig;
  assign grant_b = b_elig & ~a_elig;
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    busy_d     = busy_q;
    clr_done_d = 1'b0;
    d_en_d     = 1'b0;
    d_addr_d   = d_addr_q;
    d_d        = d_q;
`ifdef WR_ARB_ROUND_ROBIN_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d  = CLEAR;
          busy_d   = 1'b1;
          d_en_d   = 1'b1;
          d_addr_d = 5'd1;
          d_d      = '0;
        end else if (grant_a) begin
          a_ack_d  = 1'b1;
          d_en_d   = (a_addr != 5'd0);
          d_addr_d = a_addr;
          d_d      = a_data;
`ifdef WR_ARB_ROUND_ROBIN_EN
          ptr_d    = 1'b1;
`endif
        end else if (grant_b) begin
          b_ack_d  = 1'b1;
          d_en_d   = (b_addr != 5'd0);
          d_addr_d = b_addr;
          d_d      = b_data;
`ifdef WR_ARB_ROUND_ROBIN_EN
          ptr_d    = 1'b0;
`endif
        end
      end
      CLEAR: begin
        // The write address itself is the sweep counter; address 31 is the last write.
        if (d_addr_q == 5'd31) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          clr_done_d = 1'b1;
        end else begin
          d_en_d   = 1'b1;
          d_addr_d = d_addr_q + 5'd1;
          d_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
      d_en_q     <= 1'b0;
      d_addr_q   <= '0;
      d_q        <= '0;
`ifdef WR_ARB_ROUND_ROBIN_EN
      ptr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
      d_en_q     <= d_en_d;
      d_addr_q   <= d_addr_d;
      d_q        <= d_d;
`ifdef WR_ARB_ROUND_ROBIN_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign busy     = busy_q;
  assign clr_done = clr_done_q;
  assign D_En     = d_en_q;
  assign D_Addr   = d_addr_q;
  assign D        = d_q;

endmodule
